// File: rtl/ahb_wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin AHB output arbiter.
// Holds the AHB transfer-type and burst-type encodings plus the burst
// length helper used by the burst tracker.
package ahb_wrr_arb_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HburstSingle = 3'b000,
        HburstIncr   = 3'b001,
        HburstWrap4  = 3'b010,
        HburstIncr4  = 3'b011,
        HburstWrap8  = 3'b100,
        HburstIncr8  = 3'b101,
        HburstWrap16 = 3'b110,
        HburstIncr16 = 3'b111
    } hburst_e;

    localparam int unsigned BurstRemainW = 4;

    // Beats-minus-2 loaded on the NONSEQ beat. INCR is treated as a
    // 4-beat minimum hold; SINGLE never holds.
    function automatic logic [BurstRemainW-1:0] burst_load(hburst_e hburst);
        logic [BurstRemainW-1:0] load;
        unique case (hburst)
            HburstIncr, HburstWrap4, HburstIncr4: load = 4'd2;
            HburstWrap8, HburstIncr8:             load = 4'd6;
            HburstWrap16, HburstIncr16:           load = 4'd14;
            default:                              load = 4'd0;
        endcase
        return load;
    endfunction

endpackage

// File: rtl/ahb_wrr_arb_if.sv
// Bus-side signal bundle of the arbiter.
//   master : driven by the bus-matrix input stages / shared output stage
//            (requests, weights, shared-port AHB controls); sees the grant.
//   slave  : the arbiter's view (inputs above, drives grant/no_port/credit).
interface ahb_wrr_arb_if #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned PW    = 2,
    parameter int unsigned WW    = 4
);
    logic [NPORT-1:0]    req_port;
    logic [NPORT*WW-1:0] weight_cfg;
    logic                HREADYM;
    logic                HSELM;
    logic [1:0]          HTRANSM;
    logic [2:0]          HBURSTM;
    logic                HMASTLOCKM;
    logic [PW-1:0]       addr_in_port;
    logic                no_port;
    logic [WW-1:0]       credit_out;

    modport master (
        output req_port, weight_cfg, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, credit_out
    );

    modport slave (
        input  req_port, weight_cfg, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, credit_out
    );
endinterface

// File: rtl/ahb_burst_tracker.sv
// Tracks fixed-length bursts on the shared output so the grant is not
// rotated mid-burst.
//   HCLK, HRESETn       : clock, async active-low reset
//   hready_i            : transfer done on the shared port (state enable)
//   hsel_i              : slave selected by the current address phase
//   htrans_i, hburst_i  : current address-phase transfer and burst type
//   next_burst_hold_o   : burst hold value that will be registered this cycle
//   nonseq_accept_o     : a NONSEQ is being accepted by the slave this cycle
module ahb_burst_tracker
    import ahb_wrr_arb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       hready_i,
    input  logic       hsel_i,
    input  logic [1:0] htrans_i,
    input  logic [2:0] hburst_i,
    output logic       next_burst_hold_o,
    output logic       nonseq_accept_o
);

    logic [BurstRemainW-1:0] burst_remain_q, burst_remain_d;
    logic                    burst_hold_q, burst_hold_d;

    always_comb begin
        burst_remain_d = burst_remain_q;
        burst_hold_d   = burst_hold_q;
        if (hready_i) begin
            if (!hsel_i) begin
                burst_remain_d = '0;
                burst_hold_d   = 1'b0;
            end else begin
                unique case (htrans_e'(htrans_i))
                    HtransIdle: begin
                        burst_remain_d = '0;
                        burst_hold_d   = 1'b0;
                    end
                    HtransBusy: ;
                    HtransNonseq: begin
                        burst_remain_d = burst_load(hburst_e'(hburst_i));
                        burst_hold_d   = (hburst_e'(hburst_i) != HburstSingle);
                    end
                    HtransSeq: begin
                        // The beat seen with remain already at 0 is the last one.
                        if (burst_remain_q == '0) begin
                            burst_hold_d = 1'b0;
                        end else begin
                            burst_remain_d = burst_remain_q - BurstRemainW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            burst_remain_q <= '0;
            burst_hold_q   <= 1'b0;
        end else begin
            burst_remain_q <= burst_remain_d;
            burst_hold_q   <= burst_hold_d;
        end
    end

    assign next_burst_hold_o = burst_hold_d;
    assign nonseq_accept_o   = hready_i & hsel_i & (htrans_e'(htrans_i) == HtransNonseq);

endmodule

// File: rtl/ahb_wrr_arb.sv
// Weighted round-robin arbiter sharing one AHB-Lite slave port between
// NPORT bus-matrix input stages. Each port gets up to its weight of NONSEQ
// grants before rotation; fixed bursts and locked sequences hold the grant.
//   HCLK, HRESETn : clock, async active-low reset
//   bus (slave)   : req_port, weight_cfg, HREADYM, HSELM, HTRANSM, HBURSTM,
//                   HMASTLOCKM in; addr_in_port, no_port, credit_out out
module ahb_wrr_arb
    import ahb_wrr_arb_pkg::*;
#(
    parameter int unsigned NPORT = 4,
    parameter int unsigned PW    = 2,
    parameter int unsigned WW    = 4
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_wrr_arb_if.slave bus
);

    if (PW < $clog2(NPORT)) begin : g_bad_pw
        $error("ahb_wrr_arb: PW=%0d is too narrow for NPORT=%0d", PW, NPORT);
    end

    logic [PW-1:0] grant_q, grant_d;
    logic          no_port_q, no_port_d;
    logic [WW-1:0] credit_q [NPORT];
    logic [WW-1:0] credit_d [NPORT];
    logic          next_burst_hold;
    logic          nonseq_accept;

    ahb_burst_tracker u_burst_tracker (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .hready_i          (bus.HREADYM),
        .hsel_i            (bus.HSELM),
        .htrans_i          (bus.HTRANSM),
        .hburst_i          (bus.HBURSTM),
        .next_burst_hold_o (next_burst_hold),
        .nonseq_accept_o   (nonseq_accept)
    );

    function automatic logic [WW-1:0] eff_weight(logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    always_comb begin
        logic          acc;
        logic          hold;
        logic          found;
        logic [WW-1:0] cur_dec;
        int unsigned   cur;
        int unsigned   idx;
        int unsigned   pick;

        for (int unsigned p = 0; p < NPORT; p++) begin
            credit_d[p] = credit_q[p];
        end
        grant_d   = grant_q;
        no_port_d = no_port_q;
        found     = 1'b0;
        idx       = 0;
        pick      = 0;
        cur       = 32'(grant_q);
        acc       = nonseq_accept & ~no_port_q;
        hold      = next_burst_hold | bus.HMASTLOCKM;

        cur_dec = credit_q[cur];
        if (acc && cur_dec != '0) begin
            cur_dec = cur_dec - WW'(1);
        end

        if (bus.HREADYM) begin
            if (acc) begin
                credit_d[cur] = cur_dec;
            end
            if (!hold) begin
                if (no_port_q) begin
                    for (int unsigned i = 0; i < NPORT; i++) begin
                        if (!found && bus.req_port[i]) begin
                            found = 1'b1;
                            pick  = i;
                        end
                    end
                end else if (!(bus.req_port[cur] && cur_dec != '0)) begin
                    // Search starts after the current port and wraps back onto it.
                    for (int unsigned k = 1; k <= NPORT; k++) begin
                        idx = cur + k;
                        if (idx >= NPORT) begin
                            idx = idx - NPORT;
                        end
                        if (!found && bus.req_port[idx]) begin
                            found = 1'b1;
                            pick  = idx;
                        end
                    end
                    // Current port still selecting the slave (IDLE) keeps the grant.
                    if (!found && !bus.HSELM) begin
                        no_port_d = 1'b1;
                    end
                end
                // A fresh load overrides the decrement, even when landing on cur.
                if (found) begin
                    grant_d        = PW'(pick);
                    no_port_d      = 1'b0;
                    credit_d[pick] = eff_weight(bus.weight_cfg[pick*WW +: WW]);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q   <= '0;
            no_port_q <= 1'b1;
            for (int unsigned p = 0; p < NPORT; p++) begin
                credit_q[p] <= '0;
            end
        end else begin
            grant_q   <= grant_d;
            no_port_q <= no_port_d;
            for (int unsigned p = 0; p < NPORT; p++) begin
                credit_q[p] <= credit_d[p];
            end
        end
    end

    assign bus.addr_in_port = grant_q;
    assign bus.no_port      = no_port_q;
    assign bus.credit_out   = no_port_q ? '0 : credit_q[grant_q];

endmodule

// File: tb/tb_ahb_wrr_arb.sv
// Self-checking bench for ahb_wrr_arb: directed scenarios followed by a
// randomized phase, all compared against a cycle-level reference model.
module tb_ahb_wrr_arb;

    localparam int NP = 4;
    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;
    localparam logic [2:0] BuSingle = 3'b000;
    localparam logic [2:0] BuIncr8  = 3'b101;
    localparam logic [2:0] BuIncr16 = 3'b111;

    logic HCLK;
    logic HRESETn;

    ahb_wrr_arb_if #(.NPORT(4), .PW(2), .WW(4)) bus_if ();

    ahb_wrr_arb #(.NPORT(4), .PW(2), .WW(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_if)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] w_cfg;

    // Reference model state
    int m_grant;
    bit m_none;
    int m_credit [NP];
    int m_remain;
    bit m_hold;

    int       rr_exp   [5]  = '{0, 1, 2, 3, 0};
    int       wrr_exp  [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    int       wcr_exp  [8]  = '{3, 2, 1, 1, 3, 2, 1, 1};
    logic [1:0] incr8_tr [10] = '{TrNonseq, TrSeq, TrSeq, TrBusy, TrSeq,
                                  TrBusy, TrSeq, TrSeq, TrSeq, TrSeq};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_w(input int p);
        int v;
        v = int'(w_cfg[p*4 +: 4]);
        return (v == 0) ? 1 : v;
    endfunction

    // Hold length after the NONSEQ beat: total beats minus 2.
    function automatic int beats_m2(input logic [2:0] b);
        int beats;
        if (b == 3'd0) return 0;
        if (b == 3'd1) beats = 4;
        else beats = 4 << ((int'(b) - 2) / 2);
        return beats - 2;
    endfunction

    task automatic model_reset();
        m_grant  = 0;
        m_none   = 1;
        m_remain = 0;
        m_hold   = 0;
        for (int i = 0; i < NP; i++) m_credit[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic rdy, input logic sel,
                              input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        int nr;
        int c;
        int cdec;
        int p;
        bit nh;
        bit acc;
        bit found;
        if (!rdy) return;
        nr = m_remain;
        nh = m_hold;
        if (!sel || tr == TrIdle) begin
            nr = 0;
            nh = 0;
        end else if (tr == TrNonseq) begin
            nh = (bu != BuSingle);
            nr = beats_m2(bu);
        end else if (tr == TrSeq) begin
            if (nr == 0) nh = 0;
            else nr = nr - 1;
        end
        acc  = sel && (tr == TrNonseq) && !m_none;
        c    = m_grant;
        cdec = m_credit[c];
        if (acc && cdec > 0) cdec = cdec - 1;
        if (acc) m_credit[c] = cdec;
        found = 0;
        if (!(nh || lk)) begin
            if (m_none) begin
                for (int i = 0; i < NP; i++) begin
                    if (!found && req[i]) begin
                        found   = 1;
                        m_grant = i;
                    end
                end
            end else if (!(req[c] && cdec > 0)) begin
                for (int k = 1; k <= NP; k++) begin
                    p = (c + k) % NP;
                    if (!found && req[p]) begin
                        found   = 1;
                        m_grant = p;
                    end
                end
                if (!found && !sel) m_none = 1;
            end
            if (found) begin
                m_none            = 0;
                m_credit[m_grant] = eff_w(m_grant);
            end
        end
        m_remain = nr;
        m_hold   = nh;
    endtask

    // One bus cycle: entered and left at a falling edge.
    task automatic cyc(input logic [3:0] req, input logic rdy, input logic sel,
                       input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        bus_if.req_port   = req;
        bus_if.weight_cfg = w_cfg;
        bus_if.HREADYM    = rdy;
        bus_if.HSELM      = sel;
        bus_if.HTRANSM    = tr;
        bus_if.HBURSTM    = bu;
        bus_if.HMASTLOCKM = lk;
        check("addr_in_port", 32'(bus_if.addr_in_port), 32'(m_grant));
        check("no_port", 32'(bus_if.no_port), 32'(m_none));
        check("credit_out", 32'(bus_if.credit_out), 32'(m_none ? 0 : m_credit[m_grant]));
        model_step(req, rdy, sel, tr, bu, lk);
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("rst_addr", 32'(bus_if.addr_in_port), 32'd0);
        check("rst_no_port", 32'(bus_if.no_port), 32'd1);
        check("rst_credit", 32'(bus_if.credit_out), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn           = 1'b0;
        w_cfg             = 16'h1111;
        bus_if.req_port   = '0;
        bus_if.weight_cfg = w_cfg;
        bus_if.HREADYM    = 1'b1;
        bus_if.HSELM      = 1'b0;
        bus_if.HTRANSM    = TrIdle;
        bus_if.HBURSTM    = BuSingle;
        bus_if.HMASTLOCKM = 1'b0;
        @(negedge HCLK);
        do_reset();

        // Idle, then a single request from port 2
        cyc(4'b0000, 1, 0, TrIdle, BuSingle, 0);
        cyc(4'b0000, 1, 0, TrIdle, BuSingle, 0);
        cyc(4'b0100, 1, 0, TrIdle, BuSingle, 0);
        check("first_grant", 32'(bus_if.addr_in_port), 32'd2);
        check("first_grant_np", 32'(bus_if.no_port), 32'd0);

        // Plain round robin with weight 1
        w_cfg = 16'h1111;
        do_reset();
        cyc(4'hF, 1, 1, TrNonseq, BuSingle, 0);
        for (int i = 0; i < 5; i++) begin
            check("rr_grant", 32'(bus_if.addr_in_port), 32'(rr_exp[i]));
            cyc(4'hF, 1, 1, TrNonseq, BuSingle, 0);
        end

        // Weighted: port 0 weight 3, port 1 weight 1
        w_cfg = 16'h1113;
        do_reset();
        cyc(4'b0011, 1, 1, TrNonseq, BuSingle, 0);
        for (int i = 0; i < 8; i++) begin
            check("wrr_grant", 32'(bus_if.addr_in_port), 32'(wrr_exp[i]));
            check("wrr_credit", 32'(bus_if.credit_out), 32'(wcr_exp[i]));
            cyc(4'b0011, 1, 1, TrNonseq, BuSingle, 0);
        end

        // INCR8 with BUSY beats holds port 0 despite weight 1
        w_cfg = 16'h1111;
        do_reset();
        cyc(4'b0011, 1, 0, TrIdle, BuSingle, 0);
        for (int i = 0; i < 10; i++) begin
            check("incr8_hold", 32'(bus_if.addr_in_port), 32'd0);
            cyc(4'b0011, 1, 1, incr8_tr[i], BuIncr8, 0);
        end
        check("incr8_rotate", 32'(bus_if.addr_in_port), 32'd1);

        // Locked sequence on port 3
        do_reset();
        for (int i = 0; i < 4; i++) cyc(4'hF, 1, 1, TrNonseq, BuSingle, 0);
        for (int i = 0; i < 5; i++) begin
            check("lock_hold", 32'(bus_if.addr_in_port), 32'd3);
            cyc(4'hF, 1, 1, TrNonseq, BuSingle, 1);
        end
        cyc(4'hF, 1, 1, TrNonseq, BuSingle, 0);
        check("lock_release", 32'(bus_if.addr_in_port), 32'd0);

        // HREADYM low freezes everything while port 1 drops out
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1101, 0, 1, TrNonseq, BuSingle, 0);
            check("freeze_grant", 32'(bus_if.addr_in_port), 32'd0);
        end
        cyc(4'hF, 1, 0, TrIdle, BuSingle, 0);

        // Reset in the middle of an INCR16
        w_cfg = 16'h5555;
        cyc(4'hF, 1, 1, TrNonseq, BuIncr16, 0);
        cyc(4'hF, 1, 1, TrSeq, BuIncr16, 0);
        cyc(4'hF, 1, 1, TrSeq, BuIncr16, 0);
        do_reset();

        // Randomized traffic, weights (including 0) changed now and then
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) w_cfg = 16'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            cyc(4'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) != 0),
                2'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
